quad_encoder_emulator: RTL

QUAD_ENCODER_EMULATOR -- requirements
Module: quad_encoder_emulator

---
 rtl/quad_encoder_emulator.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/quad_encoder_emulator.sv
// Quadrature encoder emulator: emits N full A/B Gray cycles with P clocks per
// phase, in either direction, with abort-at-cycle-end and a one-cycle done strobe.
module quad_encoder_emulator #(
  parameter int unsigned PERIOD_WIDTH = 16,
  parameter int unsigned COUNT_WIDTH  = 16,
  parameter int unsigned MIN_PERIOD   = 2
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset,
  input  logic                    i_Start,
  input  logic [PERIOD_WIDTH-1:0] i_Period,
  input  logic                    i_Direction,
  input  logic [COUNT_WIDTH-1:0]  i_Pulse_Target,
  input  logic                    i_Abort,
  output logic                    o_Channel_A,
  output logic                    o_Channel_B,
  output logic                    o_Busy,
  output logic                    o_Done,
  output logic [COUNT_WIDTH-1:0]  o_Pulses_Sent
);

  // A zero-length phase would never expire, so the floor is at least one clock.
  localparam int unsigned MIN_PERIOD_SAFE = (MIN_PERIOD < 1) ? 1 : MIN_PERIOD;
  localparam logic [PERIOD_WIDTH-1:0] MIN_PERIOD_W = PERIOD_WIDTH'(MIN_PERIOD_SAFE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state, state_next;
  logic [PERIOD_WIDTH-1:0] period_eff, period_eff_next;
  logic                    direction, direction_next;
  logic [COUNT_WIDTH-1:0]  pulse_target, pulse_target_next;
  logic [PERIOD_WIDTH-1:0] timer, timer_next;
  logic [1:0]              phase, phase_next;
  logic                    abort_pending, abort_pending_next;
  logic                    channel_a_next, channel_b_next;
  logic                    busy_next, done_next;
  logic [COUNT_WIDTH-1:0]  pulses_next;

  logic                    abort_now_c;
  logic                    phase_end_c;
  logic [1:0]              ab_next_c;

  // Map a phase index (0..3) to (A,B); reverse is forward with channels swapped.
  function automatic logic [1:0] phase_to_ab(input logic [1:0] ph, input logic rev);
    logic [1:0] ab;
    case (ph)
      2'd0:    ab = 2'b00;
      2'd1:    ab = 2'b10;
      2'd2:    ab = 2'b11;
      default: ab = 2'b01;
    endcase
    return rev ? {ab[0], ab[1]} : ab;
  endfunction

  // State and registered outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state         <= IDLE;
      period_eff    <= '0;
      direction     <= 1'b0;
      pulse_target  <= '0;
      timer         <= '0;
      phase         <= 2'd0;
      abort_pending <= 1'b0;
      o_Channel_A   <= 1'b0;
      o_Channel_B   <= 1'b0;
      o_Busy        <= 1'b0;
      o_Done        <= 1'b0;
      o_Pulses_Sent <= '0;
    end else begin
      state         <= state_next;
      period_eff    <= period_eff_next;
      direction     <= direction_next;
      pulse_target  <= pulse_target_next;
      timer         <= timer_next;
      phase         <= phase_next;
      abort_pending <= abort_pending_next;
      o_Channel_A   <= channel_a_next;
      o_Channel_B   <= channel_b_next;
      o_Busy        <= busy_next;
      o_Done        <= done_next;
      o_Pulses_Sent <= pulses_next;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_next         = state;
    period_eff_next    = period_eff;
    direction_next     = direction;
    pulse_target_next  = pulse_target;
    timer_next         = timer;
    phase_next         = phase;
    abort_pending_next = abort_pending;
    channel_a_next     = o_Channel_A;
    channel_b_next     = o_Channel_B;
    busy_next          = o_Busy;
    done_next          = 1'b0;
    pulses_next        = o_Pulses_Sent;
    abort_now_c        = abort_pending | i_Abort;
    phase_end_c        = (timer == (period_eff - PERIOD_WIDTH'(1)));
    ab_next_c          = phase_to_ab(phase + 2'd1, direction);

    case (state)
      IDLE: begin
        if (i_Start) begin
          period_eff_next    = (i_Period < MIN_PERIOD_W) ? MIN_PERIOD_W : i_Period;
          direction_next     = i_Direction;
          pulse_target_next  = i_Pulse_Target;
          timer_next         = '0;
          phase_next         = 2'd0;
          abort_pending_next = 1'b0;
          pulses_next        = '0;
          channel_a_next     = 1'b0;
          channel_b_next     = 1'b0;
          if (i_Pulse_Target == '0) begin
            state_next = DONE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end else begin
            state_next = RUN;
            busy_next  = 1'b1;
          end
        end
      end

      RUN: begin
        abort_pending_next = abort_now_c;
        if (phase_end_c) begin
          timer_next = '0;
          if ((phase == 2'd0) && abort_now_c) begin
            // Abort seen before a new cycle begins: stop at 00 without starting it.
            state_next = DONE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end else begin
            phase_next     = phase + 2'd1;
            channel_a_next = ab_next_c[1];
            channel_b_next = ab_next_c[0];
            if (phase == 2'd3) begin
              pulses_next = o_Pulses_Sent + COUNT_WIDTH'(1);
              if ((pulses_next == pulse_target) || abort_now_c) begin
                state_next = DONE;
                busy_next  = 1'b0;
                done_next  = 1'b1;
              end
            end
          end
        end else begin
          timer_next = timer + PERIOD_WIDTH'(1);
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

endmodule
